// File: rtl/synth_note_pkg.sv
// Shared constants for the synthesizer note path: scan codes,
// FSM state encoding and the note half-period table.
package synth_note_pkg;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_EXT     = 2'd1,
      S_BRK     = 2'd2,
      S_EXT_BRK = 2'd3
   } state_t;

   localparam logic [7:0] KC_E0 = 8'hE0;
   localparam logic [7:0] KC_F0 = 8'hF0;
   localparam logic [7:0] KC_AA = 8'hAA;

   localparam logic [7:0] KC_NOTE [8] = '{
      8'h1C, 8'h1B, 8'h23, 8'h2B,
      8'h34, 8'h33, 8'h3B, 8'h42
   };

   localparam int unsigned NOTE_HALF_PERIOD [8] = '{
      11200, 9975, 8900, 8400,
      7450, 6650, 5925, 5600
   };

   // Lowest set bit wins; an empty mask yields 0.
   function automatic logic [2:0] lowest_set(input logic [7:0] m);
      logic [2:0] r;
      r = '0;
      for (int i = 7; i >= 0; i--)
         if (m[i]) r = 3'(i);
      return r;
   endfunction

endpackage

// File: rtl/keycode_to_note.sv
// Maps a PS/2 set-2 scan code to one of the eight note keys.
module keycode_to_note
   import synth_note_pkg::*;
(
   input  logic [7:0] code,
   output logic       hit,
   output logic [2:0] idx
);

   always_comb begin
      hit = 1'b0;
      idx = '0;
      for (int i = 0; i < 8; i++) begin
         if (code == KC_NOTE[i]) begin
            hit = 1'b1;
            idx = 3'(i);
         end
      end
   end

endmodule

// File: rtl/ps2_note_decoder.sv
// Tracks make/break/prefix sequences from the PS/2 byte stream and
// resolves the held note keys to one active note and its half-period.
module ps2_note_decoder
   import synth_note_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 2_000_000,
   parameter int PERIOD_W       = 20
)
(
   input  logic                clk,
   input  logic                rst,
   input  logic [7:0]          rx_data,
   input  logic                rx_valid,
   output logic [7:0]          held,
   output logic                note_on,
   output logic [2:0]          note_idx,
   output logic [PERIOD_W-1:0] half_period,
   output logic                note_start
);

   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   state_t           state;
   logic [CNT_W-1:0] tmo_cnt;
   logic             hit;
   logic [2:0]       key;
   logic [7:0]       rest;
   logic [2:0]       low;
   logic             is_make;
   logic             is_brk;
   logic             is_bat;

   keycode_to_note u_k2n (
      .code (rx_data),
      .hit  (hit),
      .idx  (key)
   );

   always_comb begin
      rest    = held & ~(8'b1 << key);
      low     = lowest_set(rest);
      is_make = rx_valid && state == S_IDLE && hit;
      is_brk  = rx_valid && state == S_BRK && hit;
      is_bat  = rx_valid && state == S_IDLE
                && rx_data == KC_AA;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= S_IDLE;
         tmo_cnt     <= '0;
         held        <= '0;
         note_on     <= 1'b0;
         note_idx    <= '0;
         half_period <= '0;
         note_start  <= 1'b0;
      end else begin
         note_start <= 1'b0;

         if (rx_valid) begin
            tmo_cnt <= '0;
            case (state)
               S_IDLE: begin
                  if (rx_data == KC_E0)
                     state <= S_EXT;
                  else if (rx_data == KC_F0)
                     state <= S_BRK;
               end
               S_EXT: begin
                  if (rx_data == KC_F0)
                     state <= S_EXT_BRK;
                  else
                     state <= S_IDLE;
               end
               default: state <= S_IDLE;
            endcase
         end else if (state != S_IDLE) begin
            // Abandon a stalled prefix so a lost byte cannot wedge us.
            if (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
               state   <= S_IDLE;
               tmo_cnt <= '0;
            end else begin
               tmo_cnt <= tmo_cnt + 1'b1;
            end
         end else begin
            tmo_cnt <= '0;
         end

         unique case (1'b1)
            is_bat: begin
               held        <= '0;
               note_on     <= 1'b0;
               half_period <= '0;
            end
            is_make: begin
               held[key]   <= 1'b1;
               note_on     <= 1'b1;
               note_idx    <= key;
               half_period <= PERIOD_W'(NOTE_HALF_PERIOD[key]);
               note_start  <= !note_on || note_idx != key;
            end
            is_brk: begin
               held[key] <= 1'b0;
               if (note_on && note_idx == key) begin
                  if (rest != '0) begin
                     note_idx    <= low;
                     half_period <= PERIOD_W'(NOTE_HALF_PERIOD[low]);
                     note_start  <= 1'b1;
                  end else begin
                     note_on     <= 1'b0;
                     half_period <= '0;
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_ps2_note_decoder.sv
// Scoreboard bench: a keyboard-level model predicts every cycle's
// outputs; a monitor pops and compares one entry per clock.
module tb_ps2_note_decoder;

   localparam int T  = 100;
   localparam int PW = 20;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [7:0]    rx_data = '0;
   logic          rx_valid = 1'b0;
   logic [7:0]    held;
   logic          note_on;
   logic [2:0]    note_idx;
   logic [PW-1:0] half_period;
   logic          note_start;

   ps2_note_decoder #(.TIMEOUT_CYCLES(T), .PERIOD_W(PW)) dut (
      .clk         (clk),
      .rst         (rst),
      .rx_data     (rx_data),
      .rx_valid    (rx_valid),
      .held        (held),
      .note_on     (note_on),
      .note_idx    (note_idx),
      .half_period (half_period),
      .note_start  (note_start)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] held;
      logic       on;
      logic [2:0] idx;
      int         hp;
      logic       start;
      bit         chk_idx;
      int         phase;
   } exp_t;

   exp_t q[$];
   int total = 0;
   int bad = 0;
   int phase = 0;

   int  hp_tab [8] = '{11200, 9975, 8900, 8400, 7450, 6650, 5925, 5600};
   byte kc_tab [8] = '{8'h1C, 8'h1B, 8'h23, 8'h2B,
                       8'h34, 8'h33, 8'h3B, 8'h42};

   // Keyboard-level model state
   bit m_held [8];
   bit m_on;
   int m_idx;
   bit m_start;
   bit saw_e0, saw_f0;
   int idle_cnt;

   function automatic int note_of(input logic [7:0] b);
      for (int i = 0; i < 8; i++)
         if (b == kc_tab[i]) return i;
      return -1;
   endfunction

   function automatic logic [7:0] held_vec();
      logic [7:0] v;
      for (int i = 0; i < 8; i++) v[i] = m_held[i];
      return v;
   endfunction

   task automatic do_make(input int k);
      m_start   = !m_on || m_idx != k;
      m_held[k] = 1;
      m_on      = 1;
      m_idx     = k;
   endtask

   task automatic do_break(input int k);
      int j;
      m_held[k] = 0;
      if (m_on && m_idx == k) begin
         j = -1;
         for (int i = 0; i < 8; i++)
            if (m_held[i] && j < 0) j = i;
         if (j >= 0) begin
            m_idx   = j;
            m_start = 1;
         end else begin
            m_on = 0;
         end
      end
   endtask

   task automatic model_step(input bit r, input bit v, input logic [7:0] d);
      int k;
      m_start = 0;
      if (r) begin
         foreach (m_held[i]) m_held[i] = 0;
         m_on = 0; m_idx = 0;
         saw_e0 = 0; saw_f0 = 0; idle_cnt = 0;
         return;
      end
      if (v) begin
         idle_cnt = 0;
         k = note_of(d);
         if (!saw_e0 && !saw_f0) begin
            if (d == 8'hE0) saw_e0 = 1;
            else if (d == 8'hF0) saw_f0 = 1;
            else if (d == 8'hAA) begin
               foreach (m_held[i]) m_held[i] = 0;
               m_on = 0;
            end else if (k >= 0) do_make(k);
         end else if (saw_e0 && !saw_f0 && d == 8'hF0) begin
            saw_f0 = 1;
         end else begin
            if (saw_f0 && !saw_e0 && k >= 0) do_break(k);
            saw_e0 = 0;
            saw_f0 = 0;
         end
      end else if (saw_e0 || saw_f0) begin
         idle_cnt++;
         if (idle_cnt == T) begin
            saw_e0 = 0; saw_f0 = 0; idle_cnt = 0;
         end
      end
   endtask

   task automatic cycle(input bit v, input logic [7:0] d, input bit r);
      exp_t e;
      @(negedge clk);
      rst      = r;
      rx_valid = v;
      rx_data  = d;
      model_step(r, v, d);
      e.held    = held_vec();
      e.on      = m_on;
      e.idx     = 3'(m_idx);
      e.hp      = m_on ? hp_tab[m_idx] : 0;
      e.start   = m_start;
      e.chk_idx = m_on || r;
      e.phase   = phase;
      q.push_back(e);
   endtask

   task automatic send(input logic [7:0] b);
      cycle(1'b1, b, 1'b0);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(1'b0, 8'($urandom), 1'b0);
   endtask

   task automatic do_reset();
      cycle(1'b0, 8'h00, 1'b1);
   endtask

   always @(posedge clk) begin
      exp_t e;
      #1;
      if (q.size() > 0) begin
         e = q.pop_front();
         total++;
         if (held !== e.held || note_on !== e.on
             || half_period !== PW'(e.hp) || note_start !== e.start
             || (e.chk_idx && note_idx !== e.idx)) begin
            bad++;
            $display("FAIL outputs phase=%0d t=%0t got held=%h on=%b idx=%0d hp=%0d start=%b want held=%h on=%b idx=%0d hp=%0d start=%b",
                     e.phase, $time, held, note_on, note_idx,
                     half_period, note_start, e.held, e.on, e.idx,
                     e.hp, e.start);
         end
      end
   end

   initial begin
      int r, gap, n;
      do_reset();
      do_reset();
      idle(2);

      phase = 1;
      send(8'h1C); idle(2);
      send(8'h33); idle(1);
      send(8'hF0); send(8'h33); idle(2);

      phase = 2;
      send(8'hF0); send(8'h1C); idle(1);
      send(8'h1C); send(8'h1C); send(8'h1C); idle(1);

      phase = 3;
      send(8'hE0); send(8'hF0); send(8'h1C); idle(1);
      send(8'hE0); send(8'h1B); idle(1);
      send(8'hF0); send(8'hF0); send(8'h1C); idle(1);

      phase = 4;
      send(8'hF0); send(8'h1C); idle(1);
      send(8'hF0); idle(T); send(8'h1C); idle(1);
      send(8'hF0); idle(T - 1); send(8'h1C); idle(1);

      phase = 5;
      send(8'h42); send(8'h2B); send(8'hAA); idle(1);
      send(8'hF0); do_reset(); send(8'h1C); idle(2);
      do_reset();

      phase = 6;
      for (int s = 0; s < 1500; s++) begin
         r = $urandom_range(0, 19);
         if (r < 10)      send(kc_tab[$urandom_range(0, 7)]);
         else if (r < 14) send(8'hF0);
         else if (r < 16) send(8'hE0);
         else if (r < 17) send(8'hAA);
         else             send(8'($urandom));
         if ($urandom_range(0, 40) == 0) gap = $urandom_range(T - 3, T + 3);
         else gap = $urandom_range(0, 2);
         idle(gap);
         if ($urandom_range(0, 200) == 0) do_reset();
      end
      idle(2);

      n = 0;
      while (q.size() > 0 && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (q.size() > 0) begin
         bad++;
         total++;
         $display("FAIL drain got pending=%0d want 0", q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/ps2_note_decoder.md
Name: ps2_note_decoder

Overview:
Upstream stage of the synthesizer tone path. It consumes the byte stream from the PS/2 receiver and tracks make, break and extended-prefix sequences. It keeps a held-key map for the eight note keys and resolves them to a single active note. The outputs are that note's index and its half-period count, which drive the note clock divider; a half-period of 0 means silence.

Parameters:
TIMEOUT_CYCLES, 2_000_000, idle clocks after a prefix byte before the FSM abandons the sequence (20 ms at 100 MHz).
PERIOD_W, 20, width of the half_period output.

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
rx_data  input  8  scan-code byte from the PS/2 receiver
rx_valid  input  1  one-cycle strobe; rx_data is valid this cycle
held  output  8  bit k = note key k currently held
note_on  output  1  an active note exists
note_idx  output  3  active note, 0 = C4 … 7 = C5
half_period  output  PERIOD_W  divider count for note_idx; 0 when note_on = 0
note_start  output  1  one-cycle pulse when the active note changes or sounds from silence

Behaviour:
- Reset: synchronous on rst, active-high. All outputs go to 0, FSM goes to S_IDLE, timeout counter goes to 0. rst mid-sequence discards any partial prefix.
- Key map (note 0..7): 1C, 1B, 23, 2B, 34, 33, 3B, 42. All other codes are non-note codes.
- Half-period table (0..7): 11200, 9975, 8900, 8400, 7450, 6650, 5925, 5600.
- All outputs are registered. For a byte accepted at cycle N, the effect is visible at N+1. half_period is updated in the same cycle as note_idx and note_on.
- At most one byte per cycle. When rx_valid = 0, rx_data is ignored.
- FSM states: S_IDLE, S_EXT, S_BRK, S_EXT_BRK. Transitions on rx_valid:
  - S_IDLE, E0 -> S_EXT.
  - S_IDLE, F0 -> S_BRK.
  - S_IDLE, AA (keyboard BAT / hot-plug) -> held cleared, note silenced, stay S_IDLE.
  - S_IDLE, note code -> make event, stay S_IDLE.
  - S_IDLE, any other byte -> ignored.
  - S_EXT, F0 -> S_EXT_BRK.
  - S_EXT, any other byte -> S_IDLE. Extended makes are ignored.
  - S_BRK, any byte -> break event if it is a note code, then S_IDLE.
  - S_EXT_BRK, any byte -> S_IDLE, ignored.
- Timeout:
  - The counter runs only outside S_IDLE and clears on every rx_valid.
  - When it reaches TIMEOUT_CYCLES-1, the FSM goes to S_IDLE next cycle and the counter clears. No key event is generated.
- Make of key k:
  - held[k] <= 1; note_idx <= k; note_on <= 1; half_period <= table[k].
  - note_start pulses if note_on was 0 or note_idx != k.
  - Typematic repeat of the current note: no change, no pulse. The most recent make always wins.
- Break of key k:
  - held[k] <= 0.
  - If k is not the active note, or note_on = 0: nothing else changes.
  - If k is the active note and other keys are still held: note_idx <= lowest-index remaining held key, half_period updated, note_start pulses.
  - If k is the active note and no keys remain: note_on <= 0, half_period <= 0, note_idx holds its value, no pulse.
- Break of a key not held is harmless; held is unchanged.
- An F0 immediately followed by another F0 treats the second F0 as a non-note break target and returns to S_IDLE.

Decomposition:
- Package synth_note_pkg holds:
  - the FSM state enum;
  - the keycode constants KC_E0, KC_F0, KC_AA and KC_NOTE[0..7];
  - the half-period table NOTE_HALF_PERIOD[0..7].
- Sub-module keycode_to_note: combinational; input byte; outputs hit (1 bit) and idx (3 bits). It is shared with any future sequencer.
- The FSM, held register, priority fallback (lowest-set-bit encoder on held masked by ~k), timeout counter and output registers live in ps2_note_decoder.

Test Plan:
- Reset then byte 1C -> next cycle: held = 01, note_idx = 0, half_period = 11200, note_on = 1, note_start high for exactly 1 cycle.
- Hold 1C, then make 33 (A4) -> note_idx = 5, half_period = 6650, pulse. Then F0 33 -> fallback to note_idx = 0, half_period = 11200, pulse, held = 01.
- F0 1C with only 1C held -> note_on = 0, half_period = 0, held = 00, no pulse. Repeated 1C 1C 1C -> one pulse only.
- E0 F0 1C -> held unchanged, FSM back in S_IDLE. E0 followed by 1C -> ignored.
- F0, then silence for TIMEOUT_CYCLES (set to 100 in bench), then 1C -> treated as a make (note 0 sounds), not a break.
- Hold 1C and 42, send AA -> held = 00, note_on = 0. Assert rst while in S_BRK, then send 1C -> treated as a make.
